hex_marquee: RTL
================

// Module: hex_marquee
// PURPOSE
//  Parametrised successor of the lab seven-segment letter display. Drives
//  N_DIGITS active-low 7-seg digits from a message ROM of MSG_LEN glyphs.
//  Scrolls the message left or right on a prescaled tick, with optional blink.
//  Per-digit blanking comes from synchronised KEY inputs; SW[9] inverts KEY sense.
//  Sits directly under the board top level (SW/KEY in, HEX out).
// PARAMETERS
//  N_DIGITS    4            number of 7-seg digits driven (1..8)
//  MSG_LEN     8            glyphs in message ROM (>= N_DIGITS)
//  MSG         {4{7'h7F},P,L,E,H}  MSG_LEN*7 bits, glyph k at [7k+6:7k], active-low
//  TICK_DIV    25_000_000   CLOCK_50 cycles per scroll tick (>= 2)
//  BLINK_TICKS 2            scroll ticks per blink half-period (>= 1)
// PORTS
//  CLOCK_50  in   1            system clock
//  RESET_N   in   1            asynchronous active-low reset
//  SW        in   10           [0] run, [1] dir (0=left,1=right), [2] blink, [9] KEY invert
//  KEY       in   N_DIGITS     raw buttons, active-low, asynchronous to CLOCK_50
//  HEX       out  7*N_DIGITS   digit i at [7i+6:7i], i=0 rightmost, active-low
//  tick_o    out  1            one-cycle pulse per scroll tick (for test/chaining)
// BEHAVIOUR
//  Reset (async assert, sync release): prescaler=0, ptr=0, blink_phase=0,
//   KEY sync flops=all 1, HEX=all 1 (blank), tick_o=0.
//  Prescaler: counts 0..TICK_DIV-1, wraps. tick_o=1 on the cycle count==TICK_DIV-1.
//   Runs regardless of SW[0]. The first tick comes TICK_DIV cycles after reset release.
//  ptr (0..MSG_LEN-1), updated only on tick with SW[0]=1:
//   dir 0: ptr=(ptr==MSG_LEN-1)?0:ptr+1; dir 1: ptr=(ptr==0)?MSG_LEN-1:ptr-1.
//   SW[0]=0 freezes ptr; the display stays static.
//  Glyph select: digit i shows MSG glyph idx=(ptr+N_DIGITS-1-i) mod MSG_LEN.
//   No arithmetic overflow: the index width is clog2(MSG_LEN+N_DIGITS).
//  Blink: blink counter counts ticks; every BLINK_TICKS ticks blink_phase toggles.
//   The counter runs even when SW[2]=0. SW[2]=1 and blink_phase=1: all digits blank (7'h7F).
//  KEY: 2-flop synchroniser per bit. key_blank[i]=~(ks[i]^SW[9]).
//   With SW[9]=0, pressing KEY[i] (low) blanks digit i. With SW[9]=1 the sense is inverted.
//   SW is treated as quasi-static and is not synchronised.
//  Output: HEX is registered. It reflects ptr/blink/KEY state with 1-cycle latency.
//   A KEY change is visible 3 cycles after the edge (2 sync + 1 output).
//  Simultaneous events: tick with dir change uses the SW[1] value sampled in that cycle.
//   Blank sources OR together; blank always wins over glyph.
//  RESET_N low mid-scroll: immediate blank and ptr=0; after release, scrolling
//   restarts from glyph 0 in the rightmost-(N_DIGITS-1) position.
// STRUCTURE
//  hex_pkg (shared): SEG_BLANK=7'h7F and glyph constants SEG_H/E/L/P/0..F, active-low.
//  Sub-module tick_divider #(DIV) (CLOCK_50, RESET_N, tick_o), reused by other labs.
//  Top: KEY synchroniser, ptr/blink registers, generate loop for per-digit mux plus
//   output register.
// TESTING  (TICK_DIV=4, BLINK_TICKS=2, defaults otherwise)
//  1 Reset: RESET_N=0 -> HEX=28'hFFFFFFF, tick_o=0. Release -> tick_o high on cycle 4, 8, 12.
//  2 Static: SW=0 -> HEX3..0 = H,E,L,P (7'h09,7'h06,7'h47,7'h0C). Unchanged after 20 ticks.
//  3 Scroll left: SW[0]=1 -> after 1 tick HEX3..0=E,L,P,blank. After 8 ticks back to H,E,L,P.
//  4 Scroll right: SW[1:0]=2'b11 from ptr=0 -> ptr=7. HEX3..0=blank,H,E,L. Wraps after 8 ticks.
//  5 Blink: SW[2]=1 -> HEX toggles all-blank/message every 2 ticks. SW[2]=0 restores immediately.
//  6 KEY: KEY[2]=0, SW[9]=0 -> HEX2 blank 3 cycles later. SW[9]=1 with KEY=4'hF -> all
//    blank; with KEY=4'h0 -> message. Assert RESET_N mid-scroll -> blank, ptr=0.

Source files
------------

// File: rtl/hex_pkg.sv
// rtl/hex_pkg.sv - shared active-low seven-segment glyph constants and helpers
package hex_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Letters used by the default marquee message.
  localparam logic [6:0] SEG_H = 7'h09;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_L = 7'h47;
  localparam logic [6:0] SEG_P = 7'h0C;

  // Hexadecimal digits (SEG_E above doubles as the digit E).
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Nibble to glyph, for labs that show numeric values.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

  // Blanking always overrides the glyph.
  function automatic logic [6:0] seg_mask(input logic [6:0] glyph, input logic blank);
    return blank ? SEG_BLANK : glyph;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running prescaler emitting one pulse every DIV cycles
module tick_divider #(
  parameter int DIV = 25_000_000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; the pulse marks the final count of each period.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_o = (cnt == LAST);

endmodule

// File: rtl/hex_marquee.sv
// rtl/hex_marquee.sv - scrolling, blinking, key-blankable seven-segment message display
module hex_marquee
  import hex_pkg::*;
#(
  parameter int                   N_DIGITS    = 4,
  parameter int                   MSG_LEN     = 8,
  parameter logic [MSG_LEN*7-1:0] MSG         = {{4{SEG_BLANK}}, SEG_P, SEG_L, SEG_E, SEG_H},
  parameter int                   TICK_DIV    = 25_000_000,
  parameter int                   BLINK_TICKS = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic [9:0]            SW,
  input  logic [N_DIGITS-1:0]   KEY,
  output logic [7*N_DIGITS-1:0] HEX,
  output logic                  tick_o
);

  localparam int PTR_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  // Wide enough for ptr + (N_DIGITS-1) without wrapping before the modulo.
  localparam int IDX_W = $clog2(MSG_LEN + N_DIGITS);
  localparam int BCW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MSG_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LEN    = IDX_W'(MSG_LEN);
  localparam logic [BCW-1:0]   BLINK_LAST = BCW'(BLINK_TICKS - 1);

  logic                  tick;
  logic                  run;
  logic                  dir;
  logic                  blink_en;
  logic                  key_inv;
  logic                  unused_sw;
  logic [N_DIGITS-1:0]   key_meta;
  logic [N_DIGITS-1:0]   key_sync;
  logic [N_DIGITS-1:0]   key_blank;
  logic [PTR_W-1:0]      ptr;
  logic [BCW-1:0]        blink_cnt;
  logic                  blink_phase;
  logic [6:0]            rom [MSG_LEN];
  logic [7*N_DIGITS-1:0] hex_next;

  // Switches are quasi-static board inputs, used without synchronisation.
  assign run       = SW[0];
  assign dir       = SW[1];
  assign blink_en  = SW[2];
  assign key_inv   = SW[9];
  assign unused_sw = ^SW[8:3];

  tick_divider #(
    .DIV (TICK_DIV)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .tick_o   (tick)
  );

  assign tick_o = tick;

  // Two-flop synchroniser for the asynchronous push buttons; idle (released) is 1.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      key_meta <= KEY;
      key_sync <= key_meta;
    end
  end

  // Scroll pointer: steps once per tick while running, wrapping in either direction.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr <= '0;
    end else if (tick && run) begin
      if (!dir) begin
        ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end else begin
        ptr <= (ptr == '0) ? PTR_LAST : ptr - 1'b1;
      end
    end
  end

  // Blink phase flips every BLINK_TICKS ticks; it keeps running while blink is off.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Unpack the message parameter into addressable glyphs.
  for (genvar k = 0; k < MSG_LEN; k++) begin : g_rom
    assign rom[k] = MSG[7*k +: 7];
  end

  // Per-digit glyph selection: digit i shows glyph (ptr + N_DIGITS-1-i) mod MSG_LEN.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    localparam logic [IDX_W-1:0] OFFS = IDX_W'(N_DIGITS - 1 - i);

    logic [IDX_W-1:0] sum;
    logic [PTR_W-1:0] sel;
    logic             blank;

    // ptr < MSG_LEN and OFFS < MSG_LEN, so one conditional subtract is a full modulo.
    assign sum = IDX_W'(ptr) + OFFS;
    assign sel = (sum >= IDX_LEN) ? PTR_W'(sum - IDX_LEN) : PTR_W'(sum);

    assign key_blank[i] = ~(key_sync[i] ^ key_inv);
    assign blank        = key_blank[i] | (blink_en & blink_phase);

    assign hex_next[7*i +: 7] = seg_mask(rom[sel], blank);
  end

  // Registered display drive; reset leaves every digit dark.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      HEX <= '1;
    end else begin
      HEX <= hex_next;
    end
  end

endmodule
